// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch with pause and adjust modes, driving a
// multiplexed 4-digit 7-segment display. All timing comes in as clk-domain
// single-cycle tick enables from the master clock divider.
//
// Ports:
//   clk        system clock, all logic on posedge
//   RESET      synchronous active-high reset, highest priority
//   tick_1hz   count tick (ignored in adjust mode or while paused)
//   tick_2hz   adjust-mode increment of the selected field
//   tick_fast  advances the display mux index
//   blink      level; blanks the selected field while adjusting
//   SEL        adjust field select: 0 = minutes, 1 = seconds
//   ADJ        level; 1 = adjust mode
//   pause      one-cycle pulse; toggles paused
//   sec_o/sec_t/min_o/min_t  BCD digits of the current value
//   paused     current paused state
//   seg        segments {g,f,e,d,c,b,a}
//   an         digit enables, an[0] = rightmost digit
module stopwatch_core #(
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       tick_fast,
   input  logic       blink,
   input  logic       SEL,
   input  logic       ADJ,
   input  logic       pause,
   output logic [3:0] sec_o,
   output logic [2:0] sec_t,
   output logic [3:0] min_o,
   output logic [2:0] min_t,
   output logic       paused,
   output logic [6:0] seg,
   output logic [3:0] an
);

   logic [3:0] sec_o_q, sec_o_d, min_o_q, min_o_d;
   logic [2:0] sec_t_q, sec_t_d, min_t_q, min_t_d;
   logic       paused_q, paused_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] seg_q, seg_d;
   logic [3:0] an_q, an_d;
   logic [3:0] dig_d;
   logic       cnt_en, inc_sec, inc_min, blank;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'b0111111;
         4'd1:    glyph = 7'b0000110;
         4'd2:    glyph = 7'b1011011;
         4'd3:    glyph = 7'b1001111;
         4'd4:    glyph = 7'b1100110;
         4'd5:    glyph = 7'b1101101;
         4'd6:    glyph = 7'b1111101;
         4'd7:    glyph = 7'b0000111;
         4'd8:    glyph = 7'b1111111;
         4'd9:    glyph = 7'b1101111;
         default: glyph = 7'b0000000;
      endcase
   endfunction

   always_comb begin
      sec_o_d  = sec_o_q;
      sec_t_d  = sec_t_q;
      min_o_d  = min_o_q;
      min_t_d  = min_t_q;
      // pause and tick in the same cycle: gating uses the pre-toggle state
      cnt_en   = tick_1hz & ~ADJ & ~paused_q;
      inc_sec  = cnt_en | (ADJ & tick_2hz & SEL);
      // minutes step on a seconds rollover only when counting; adjust
      // increments never carry between fields
      inc_min  = (cnt_en & (sec_o_q == 4'd9) & (sec_t_q == 3'd5))
               | (ADJ & tick_2hz & ~SEL);
      paused_d = paused_q ^ pause;
      idx_d    = idx_q + {1'b0, tick_fast};

      if (inc_sec) begin
         if (sec_o_q == 4'd9) begin
            sec_o_d = 4'd0;
            sec_t_d = (sec_t_q == 3'd5) ? 3'd0 : sec_t_q + 3'd1;
         end else begin
            sec_o_d = sec_o_q + 4'd1;
         end
      end
      if (inc_min) begin
         if (min_o_q == 4'd9) begin
            min_o_d = 4'd0;
            min_t_d = (min_t_q == 3'd5) ? 3'd0 : min_t_q + 3'd1;
         end else begin
            min_o_d = min_o_q + 4'd1;
         end
      end

      // seg/an are built from next-state digits and index so the glyph
      // always matches the enabled anode and reflects counter changes at once
      case (idx_d)
         2'd0:    dig_d = sec_o_d;
         2'd1:    dig_d = {1'b0, sec_t_d};
         2'd2:    dig_d = min_o_d;
         default: dig_d = {1'b0, min_t_d};
      endcase

      // seconds pair is indices 0-1, minutes pair is 2-3
      blank = ADJ & blink & (SEL ? ~idx_d[1] : idx_d[1]);
      seg_d = blank ? 7'b0000000 : glyph(dig_d);
      if (SEG_ACTIVE_LOW) seg_d = ~seg_d;
      an_d  = 4'b0001 << idx_d;
      if (AN_ACTIVE_LOW) an_d = ~an_d;
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         sec_o_q  <= 4'd0;
         sec_t_q  <= 3'd0;
         min_o_q  <= 4'd0;
         min_t_q  <= 3'd0;
         paused_q <= 1'b0;
         idx_q    <= 2'd0;
         seg_q    <= SEG_ACTIVE_LOW ? ~glyph(4'd0) : glyph(4'd0);
         an_q     <= AN_ACTIVE_LOW ? 4'b1110 : 4'b0001;
      end else begin
         sec_o_q  <= sec_o_d;
         sec_t_q  <= sec_t_d;
         min_o_q  <= min_o_d;
         min_t_q  <= min_t_d;
         paused_q <= paused_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   // BCD codes 10-15 cannot be produced by the carry chain
   always_ff @(posedge clk) begin
      if (!RESET) assert (dig_d <= 4'd9);
   end

   assign sec_o  = sec_o_q;
   assign sec_t  = sec_t_q;
   assign min_o  = min_o_q;
   assign min_t  = min_t_q;
   assign paused = paused_q;
   assign seg    = seg_q;
   assign an     = an_q;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

   localparam bit SEG_AL = 1'b1;
   localparam bit AN_AL  = 1'b1;
   localparam logic [6:0] GLY [10] = '{7'b0111111, 7'b0000110, 7'b1011011,
      7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111};

   logic clk = 1'b0;
   logic RESET, tick_1hz, tick_2hz, tick_fast, blink, SEL, ADJ, pause;
   logic [3:0] sec_o, min_o, an;
   logic [2:0] sec_t, min_t;
   logic       paused;
   logic [6:0] seg;

   stopwatch_core #(.SEG_ACTIVE_LOW(SEG_AL), .AN_ACTIVE_LOW(AN_AL)) dut (
      .clk(clk), .RESET(RESET), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .tick_fast(tick_fast), .blink(blink), .SEL(SEL), .ADJ(ADJ),
      .pause(pause), .sec_o(sec_o), .sec_t(sec_t), .min_o(min_o),
      .min_t(min_t), .paused(paused), .seg(seg), .an(an));

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int so, st, mo, mt, p;
      logic [6:0] seg;
      logic [3:0] an;
   } exp_t;

   exp_t q[$];
   int cyc = 0;
   int checks = 0, errors = 0;

   // reference model state: plain minutes/seconds integers
   int m_min = 0, m_sec = 0, m_p = 0, m_idx = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   // monitor: compares everything the DUT registered on the edge a queued
   // expectation was targeted at
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("sec_o", int'(sec_o), e.so);
            chk("sec_t", int'(sec_t), e.st);
            chk("min_o", int'(min_o), e.mo);
            chk("min_t", int'(min_t), e.mt);
            chk("paused", int'(paused), e.p);
            chk("seg", int'(seg), int'(e.seg));
            chk("an", int'(an), int'(e.an));
         end
      end
   end

   task automatic step(input bit r, t1, t2, tf, bl, sl, ad, ps);
      exp_t e;
      int d [4];
      bit blank;
      logic [6:0] g;
      RESET = r; tick_1hz = t1; tick_2hz = t2; tick_fast = tf;
      blink = bl; SEL = sl; ADJ = ad; pause = ps;
      if (r) begin
         m_min = 0; m_sec = 0; m_p = 0; m_idx = 0;
      end else begin
         if (!ad && t1 && !m_p) begin
            m_sec = (m_min * 60 + m_sec + 1) % 3600;
            m_min = m_sec / 60;
            m_sec = m_sec % 60;
         end
         if (ad && t2) begin
            if (sl) m_sec = (m_sec + 1) % 60;
            else    m_min = (m_min + 1) % 60;
         end
         if (ps) m_p = 1 - m_p;
         if (tf) m_idx = (m_idx + 1) % 4;
      end
      d[0] = m_sec % 10; d[1] = m_sec / 10; d[2] = m_min % 10; d[3] = m_min / 10;
      blank = !r && ad && bl && (sl ? (m_idx < 2) : (m_idx >= 2));
      g = blank ? 7'b0000000 : GLY[d[m_idx]];
      e.cyc = cyc + 1;
      e.so = d[0]; e.st = d[1]; e.mo = d[2]; e.mt = d[3]; e.p = m_p;
      e.seg = SEG_AL ? ~g : g;
      e.an  = AN_AL ? ~(4'b0001 << m_idx) : (4'b0001 << m_idx);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit a, s, b;
      RESET = 1'b1; tick_1hz = 0; tick_2hz = 0; tick_fast = 0;
      blink = 0; SEL = 0; ADJ = 0; pause = 0;
      @(posedge clk); #1;

      // reset, then ten count ticks
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 10; i++) begin step(0, 1, 0, 0, 0, 0, 0, 0); idle(1); end

      // preload 59:59 through adjust, then one count tick wraps to 00:00
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      idle(1);

      // seconds adjust wrap without minute carry; tick_1hz ignored in adjust
      for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 58; i++) step(0, 0, 1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1, 1, 0);
      step(0, 1, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);

      // pause coincident with a tick, further ticks held, second pause resumes
      step(0, 1, 0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 0, 0);

      // 12:34 display walk, then blink the minutes pair
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0, 0, 0);

      // reset mid-adjust while paused, then adjust increments from 00
      step(0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 1, 0, 0, 0, 1, 0);
      step(1, 0, 1, 1, 1, 0, 1, 0);
      step(0, 0, 1, 0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 0, 1, 1, 0);

      // randomized traffic; ADJ/SEL/blink change in dwell runs
      a = 0; s = 0; b = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) a = ~a;
         if ($urandom_range(0, 19) == 0) s = ~s;
         if ($urandom_range(0, 9) == 0) b = ~b;
         step($urandom_range(0, 999) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 0,
              b, s, a,
              $urandom_range(0, 39) == 0);
      end

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
